// File: rtl/mem_arb_pkg.sv
// Shared types and default geometry for the data-memory arbiter.
// Round-robin selection is enabled by defining MEM_ARB_ROUND_ROBIN_EN.
package mem_arb_pkg;

  localparam int MEM_WORDS_DEFAULT   = 41;
  localparam int STACK_WORDS_DEFAULT = 40;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } arb_state_t;

  typedef logic req_id_t;

endpackage

// File: rtl/mem_addr_check.sv
// Combinational signed range check for a data-memory word address.
// Valid span is -STACK_WORDS .. MEM_WORDS-1; negatives address the stack.
module mem_addr_check import mem_arb_pkg::*; #(
  parameter int MEM_WORDS   = MEM_WORDS_DEFAULT,
  parameter int STACK_WORDS = STACK_WORDS_DEFAULT
) (
  input  logic [31:0] addr,
  output logic        in_range
);

  localparam logic signed [31:0] LOW_ADDR  = -STACK_WORDS;
  localparam logic signed [31:0] HIGH_ADDR = MEM_WORDS - 1;

  assign in_range = ($signed(addr) >= LOW_ADDR) && ($signed(addr) <= HIGH_ADDR);

endmodule

// File: rtl/data_mem_arbiter.sv
// Two-requester arbiter/sequencer for the single-ported data memory.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin ties; default is fixed r0 priority.
module data_mem_arbiter import mem_arb_pkg::*; #(
  parameter int MEM_WORDS   = MEM_WORDS_DEFAULT,
  parameter int STACK_WORDS = STACK_WORDS_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        r0_req,
  input  logic        r0_we,
  input  logic [31:0] r0_addr,
  input  logic [31:0] r0_wdata,
  output logic        r0_gnt,
  output logic        r0_rsp_valid,
  output logic        r0_rsp_err,
  output logic [31:0] r0_rdata,
  input  logic        r1_req,
  input  logic        r1_we,
  input  logic [31:0] r1_addr,
  input  logic [31:0] r1_wdata,
  output logic        r1_gnt,
  output logic        r1_rsp_valid,
  output logic        r1_rsp_err,
  output logic [31:0] r1_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [31:0] mem_rdata
);

  arb_state_t  state, state_nxt;
  req_id_t     sel_id, lat_id;
  logic        any_req, sel_we, sel_in_range;
  logic        lat_we, lat_in_range;
  logic [31:0] sel_addr, sel_wdata;
  logic        accept, resp_now, resp_err;
  logic [31:0] resp_rdata;

  assign any_req = r0_req | r1_req;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // Pointer to the requester served last; starts at r1 so r0 wins the first tie.
  req_id_t last_id;

  always_ff @(posedge clock) begin
    if (reset)
      last_id <= 1'b1;
    else if (accept)
      last_id <= sel_id;
  end

  assign sel_id = (r0_req && r1_req) ? ~last_id : ~r0_req;
`else
  assign sel_id = ~r0_req;
`endif

  assign sel_we    = sel_id ? r1_we    : r0_we;
  assign sel_addr  = sel_id ? r1_addr  : r0_addr;
  assign sel_wdata = sel_id ? r1_wdata : r0_wdata;

  mem_addr_check #(
    .MEM_WORDS   (MEM_WORDS),
    .STACK_WORDS (STACK_WORDS)
  ) u_addr_check (
    .addr     (sel_addr),
    .in_range (sel_in_range)
  );

  always_ff @(posedge clock) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    accept     = 1'b0;
    resp_now   = 1'b0;
    resp_err   = 1'b0;
    resp_rdata = '0;
    case (state)
      IDLE: begin
        if (any_req) begin
          accept    = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (lat_in_range && !lat_we) begin
          state_nxt = WAIT;
        end else begin
          state_nxt = RESP;
          resp_now  = 1'b1;
          resp_err  = ~lat_in_range;
        end
      end
      WAIT: begin
        state_nxt  = RESP;
        resp_now   = 1'b1;
        resp_rdata = mem_rdata;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Strobes and responses are registered so they line up with the state they belong to.
  always_ff @(posedge clock) begin
    if (reset) begin
      r0_gnt       <= 1'b0;
      r1_gnt       <= 1'b0;
      r0_rsp_valid <= 1'b0;
      r1_rsp_valid <= 1'b0;
      r0_rsp_err   <= 1'b0;
      r1_rsp_err   <= 1'b0;
      r0_rdata     <= '0;
      r1_rdata     <= '0;
      mem_we       <= 1'b0;
      mem_re       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      lat_id       <= 1'b0;
      lat_we       <= 1'b0;
      lat_in_range <= 1'b0;
    end else begin
      r0_gnt       <= accept && !sel_id;
      r1_gnt       <= accept &&  sel_id;
      mem_we       <= accept &&  sel_we && sel_in_range;
      mem_re       <= accept && !sel_we && sel_in_range;
      r0_rsp_valid <= resp_now && !lat_id;
      r1_rsp_valid <= resp_now &&  lat_id;
      r0_rsp_err   <= resp_now && !lat_id && resp_err;
      r1_rsp_err   <= resp_now &&  lat_id && resp_err;
      if (accept) begin
        lat_id       <= sel_id;
        lat_we       <= sel_we;
        lat_in_range <= sel_in_range;
        mem_addr     <= sel_addr;
        mem_wdata    <= sel_wdata;
      end
      if (resp_now && !lat_id)
        r0_rdata <= resp_rdata;
      if (resp_now && lat_id)
        r1_rdata <= resp_rdata;
    end
  end

endmodule
